// File: rtl/opfetch_seq.sv
// Opcode fetch sequencer: assembles an optional page-prefix byte and an
// opcode byte into an (opcode, page) pair for the decoder. It injects the
// HARDI opcode when an interrupt is pending between instructions, and it
// tags instructions that a previous skip request asked to be skipped.
module opfetch_seq (
  input  logic       i_EMUCLK,
  input  logic       i_RESET,
  input  logic [7:0] i_BYTE,
  input  logic       i_BYTE_VLD,
  output logic       o_BYTE_RDY,
  output logic       o_PC_INC,
  output logic [7:0] o_OPCODE,
  output logic [2:0] o_OPCODE_PAGE,
  output logic       o_OP_VLD,
  input  logic       i_OP_ACK,
  output logic       o_OP_SKIP,
  input  logic       i_SKIP_SET,
  input  logic       i_IRQ,
  output logic       o_IRQ_TAKEN
);

  typedef enum logic [1:0] {
    FETCH1 = 2'd0,
    FETCH2 = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam logic [7:0] HARDI_OPCODE = 8'h73;

  state_e     state_q, state_d;
  logic [2:0] page_store_q, page_store_d;
  logic       skip_pend_q, skip_pend_d;
  logic       hardi_q, hardi_d;
  logic [7:0] opcode_q, opcode_d;
  logic [2:0] page_q, page_d;
  logic       op_vld_q, op_vld_d;
  logic       op_skip_q, op_skip_d;
  logic       pc_inc_q, pc_inc_d;
  logic       irq_taken_q, irq_taken_d;

  logic       byte_rdy;
  logic       xfer;
  logic [2:0] prefix_page;

  // Page selected by a prefix byte; 0 means the byte is not a prefix.
  always_comb begin
    prefix_page = 3'd0;
    case (i_BYTE)
      8'h48:   prefix_page = 3'd1;
      8'h60:   prefix_page = 3'd2;
      8'h64:   prefix_page = 3'd3;
      8'h70:   prefix_page = 3'd4;
      8'h74:   prefix_page = 3'd5;
      default: prefix_page = 3'd0;
    endcase
  end

  // Ready in the fetch states; a pending interrupt blocks the first byte
  // so HARDI wins the slot, and reset always blocks consumption.
  always_comb begin
    byte_rdy = 1'b0;
    if (!i_RESET) begin
      byte_rdy = ((state_q == FETCH1) && !i_IRQ) || (state_q == FETCH2);
    end
    xfer = byte_rdy && i_BYTE_VLD;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    page_store_d = page_store_q;
    hardi_d      = hardi_q;
    opcode_d     = opcode_q;
    page_d       = page_q;
    op_vld_d     = op_vld_q;
    op_skip_d    = op_skip_q;
    pc_inc_d     = xfer;
    irq_taken_d  = 1'b0;
    // A skip request arriving on the latch cycle survives the clear below,
    // so it lands on the following instruction.
    skip_pend_d  = skip_pend_q | i_SKIP_SET;

    case (state_q)
      FETCH1: begin
        if (i_IRQ) begin
          // HARDI is never skipped and leaves the pending flag untouched.
          opcode_d  = HARDI_OPCODE;
          page_d    = 3'd0;
          op_skip_d = 1'b0;
          hardi_d   = 1'b1;
          op_vld_d  = 1'b1;
          state_d   = HOLD;
        end else if (xfer) begin
          if (prefix_page != 3'd0) begin
            page_store_d = prefix_page;
            state_d      = FETCH2;
          end else begin
            opcode_d    = i_BYTE;
            page_d      = 3'd0;
            op_skip_d   = skip_pend_q;
            skip_pend_d = i_SKIP_SET;
            hardi_d     = 1'b0;
            op_vld_d    = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      FETCH2: begin
        if (xfer) begin
          opcode_d    = i_BYTE;
          page_d      = page_store_q;
          op_skip_d   = skip_pend_q;
          skip_pend_d = i_SKIP_SET;
          hardi_d     = 1'b0;
          op_vld_d    = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (i_OP_ACK) begin
          op_vld_d    = 1'b0;
          irq_taken_d = hardi_q;
          hardi_d     = 1'b0;
          state_d     = FETCH1;
        end
      end
      default: begin
        op_vld_d = 1'b0;
        state_d  = FETCH1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RESET) begin
      state_q      <= FETCH1;
      page_store_q <= 3'd0;
      skip_pend_q  <= 1'b0;
      hardi_q      <= 1'b0;
      opcode_q     <= 8'h00;
      page_q       <= 3'd0;
      op_vld_q     <= 1'b0;
      op_skip_q    <= 1'b0;
      pc_inc_q     <= 1'b0;
      irq_taken_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_store_q <= page_store_d;
      skip_pend_q  <= skip_pend_d;
      hardi_q      <= hardi_d;
      opcode_q     <= opcode_d;
      page_q       <= page_d;
      op_vld_q     <= op_vld_d;
      op_skip_q    <= op_skip_d;
      pc_inc_q     <= pc_inc_d;
      irq_taken_q  <= irq_taken_d;
    end
  end

  assign o_BYTE_RDY    = byte_rdy;
  assign o_PC_INC      = pc_inc_q;
  assign o_OPCODE      = opcode_q;
  assign o_OPCODE_PAGE = page_q;
  assign o_OP_VLD      = op_vld_q;
  assign o_OP_SKIP     = op_skip_q;
  assign o_IRQ_TAKEN   = irq_taken_q;

endmodule

// File: doc/opfetch_seq.md
OPFETCH_SEQ -- requirements
Module: ika87ad_opfetch_seq

Interface
REQ-001 SHALL have these ports, in this order (name, direction, width, meaning):
- i_EMUCLK, in, 1: single clock; all state changes on its rising edge.
- i_RESET, in, 1: reset, synchronous and active-high.
- i_BYTE, in, 8: opcode byte from the bus unit.
- i_BYTE_VLD, in, 1: i_BYTE is valid.
- o_BYTE_RDY, out, 1: sequencer accepts i_BYTE this cycle.
- o_PC_INC, out, 1: one-cycle pulse per byte consumed.
- o_OPCODE, out, 8: final opcode to the decoder.
- o_OPCODE_PAGE, out, 3: decoder page, 0..5.
- o_OP_VLD, out, 1: o_OPCODE and o_OPCODE_PAGE are valid.
- i_OP_ACK, in, 1: microcode sequencer takes the opcode.
- o_OP_SKIP, out, 1: the presented instruction is to be skipped.
- i_SKIP_SET, in, 1: one-cycle request to skip the next instruction.
- i_IRQ, in, 1: pending-interrupt level.
- o_IRQ_TAKEN, out, 1: one-cycle pulse when the injected HARDI is acked.

Function
REQ-002 SHALL implement states FETCH1, FETCH2 and HOLD, encoded in 2 bits.
REQ-003 SHALL assert o_BYTE_RDY only in FETCH1 or FETCH2. A byte transfers when i_BYTE_VLD and o_BYTE_RDY are both 1. o_PC_INC SHALL equal that transfer condition, registered so it appears one cycle after the transfer.
REQ-004 In FETCH1, a transferred byte SHALL be classified as follows:
- 0x48 → page 1.
- 0x60 → page 2.
- 0x64 → page 3.
- 0x70 → page 4.
- 0x74 → page 5.
- Any prefix byte: store the page, go to FETCH2.
- Any other byte: latch it as the opcode with page 0, go to HOLD.
REQ-005 In FETCH2, any transferred byte SHALL be latched as the opcode with the stored page, then go to HOLD. Prefix values are not reinterpreted in FETCH2.
REQ-006 In HOLD, o_OP_VLD SHALL be 1. o_OPCODE, o_OPCODE_PAGE and o_OP_SKIP SHALL stay stable until i_OP_ACK. On i_OP_ACK, go to FETCH1 on the next edge.
REQ-007 o_OP_VLD SHALL be 0 in FETCH1 and FETCH2. i_OP_ACK is ignored when o_OP_VLD is 0.
REQ-008 Interrupt injection: in FETCH1, if i_IRQ is 1, the sequencer SHALL present opcode 0x73 with page 0 (HARDI) in HOLD without consuming a byte. In that cycle o_BYTE_RDY is 0 and o_PC_INC is 0.
REQ-009 i_IRQ SHALL be sampled only in FETCH1. An interrupt never splits a prefix from its second byte. i_IRQ asserted in FETCH2 or HOLD waits for the next FETCH1.
REQ-010 o_IRQ_TAKEN SHALL pulse for one cycle on the i_OP_ACK of an injected HARDI only.
REQ-011 Skip:
- i_SKIP_SET in any state sets a skip-pending flag.
- The flag is copied into o_OP_SKIP when the next opcode is latched by a byte fetch.
- The flag clears when that copy happens.
- An injected HARDI is never skipped and leaves the flag set.
- i_SKIP_SET coinciding with the latch of an opcode applies to the following instruction, not the one being latched.
REQ-012 Simultaneous events: in FETCH1 with i_IRQ=1 and i_BYTE_VLD=1, the interrupt wins and the byte is not consumed. In HOLD with i_OP_ACK=1 and i_IRQ=1, the next cycle is FETCH1 and the injection occurs there.
REQ-013 A page value of 6 or 7 SHALL never appear on o_OPCODE_PAGE.
REQ-014 Outputs SHALL be registered, except o_BYTE_RDY, which is a decode of the state and i_IRQ.

Reset
REQ-015 On i_RESET=1 at a clock edge, the block SHALL set:
- state = FETCH1, skip flag = 0, stored page = 0;
- o_OPCODE = 0x00, o_OPCODE_PAGE = 0;
- o_OP_VLD = 0, o_OP_SKIP = 0, o_PC_INC = 0, o_IRQ_TAKEN = 0.
REQ-016 Reset SHALL take priority over all inputs. Reset in FETCH2 or HOLD abandons the partial or pending instruction. o_BYTE_RDY SHALL be 0 while i_RESET is 1.

Verification
REQ-017 Plain opcode: feed 0x54 with VLD=1, ACK on the first o_OP_VLD → OPCODE=0x54, PAGE=0, exactly one o_PC_INC pulse, return to FETCH1.
REQ-018 Prefixed opcode: feed 0x74 then 0x8D → OPCODE=0x8D, PAGE=5, two o_PC_INC pulses. Repeat for 0x48, 0x60, 0x64 and 0x70 giving pages 1, 2, 3 and 4.
REQ-019 Backpressure: hold i_OP_ACK=0 for 5 cycles after valid while i_BYTE_VLD=1 → o_BYTE_RDY stays 0, no o_PC_INC pulse, outputs stable throughout.
REQ-020 Interrupt:
- i_IRQ=1 in FETCH2 after 0x60 → 0x60-page opcode completes first, then HARDI 0x73/page 0.
- HARDI ack → one o_IRQ_TAKEN pulse.
- i_IRQ with i_BYTE_VLD in FETCH1 → byte not consumed.
REQ-021 Skip: pulse i_SKIP_SET, then i_IRQ=1 → HARDI presented with o_OP_SKIP=0. Next fetched 0x48/0x2A presents o_OP_SKIP=1, and the instruction after it has o_OP_SKIP=0.
REQ-022 Reset mid-op: assert i_RESET in FETCH2 after 0x70 → next byte 0x41 decodes as PAGE=0, OPCODE=0x41.
